// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives imem readAddr, buffers words in a
// 2-deep queue for decode (valid/ready), handles redirects and halt words.
// Ports: clk, reset (sync, active-high); readAddr/instr to the imem;
//   redirect_valid/redirect_addr from branch resolution;
//   out_valid/out_ready/out_instr/out_pc to decode; halted, count status.
module imem_fetch_ctrl #(
  parameter int              n          = 32,
  parameter int              r          = 7,
  parameter logic [r-1:0]    RESET_PC   = '0,
  parameter logic [n-1:0]    HALT_INSTR = '1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [r-1:0] readAddr,
  input  logic [n-1:0] instr,
  input  logic         redirect_valid,
  input  logic [r-1:0] redirect_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_instr,
  output logic [r-1:0] out_pc,
  output logic         halted,
  output logic [1:0]   count
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_e;

  state_e       state_q, state_d;
  logic [r-1:0] fetch_pc_q, fetch_pc_d;
  logic [n-1:0] head_instr_q, head_instr_d;
  logic [r-1:0] head_pc_q, head_pc_d;
  logic [n-1:0] tail_instr_q, tail_instr_d;
  logic [r-1:0] tail_pc_q, tail_pc_d;
  logic [1:0]   count_q, count_d;

  logic deq;
  logic enq;
  logic full;

  assign full = (count_q == 2'd2);
  assign deq  = (count_q != 2'd0) & out_ready;
  // A pop frees a slot in the same cycle, so a full queue can
  // still accept a word when decode is draining it.
  assign enq  = (state_q == FETCH) & ~redirect_valid & (~full | deq);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    count_d      = count_q;

    if (redirect_valid) begin
      // Flush; a same-cycle pop is already taken by decode.
      state_d    = FETCH;
      fetch_pc_d = redirect_addr;
      count_d    = 2'd0;
    end else begin
      if (enq) begin
        fetch_pc_d = fetch_pc_q + {{(r-1){1'b0}}, 1'b1};
        if (instr == HALT_INSTR) begin
          state_d = HALTED;
        end
      end
      unique case ({enq, deq})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_d = instr;
            head_pc_d    = fetch_pc_q;
          end else begin
            tail_instr_d = instr;
            tail_pc_d    = fetch_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (full) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (full) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = instr;
            tail_pc_d    = fetch_pc_q;
          end else begin
            head_instr_d = instr;
            head_pc_d    = fetch_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      count_q      <= count_d;
    end
  end

  assign readAddr  = fetch_pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;
  assign halted    = (state_q == HALTED);
  assign count     = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural imem array.
// Checks reset, streaming, backpressure, redirect, halt, wrap.
module tb_imem_fetch_ctrl;

  localparam int N = 32;
  localparam int R = 7;
  localparam logic [N-1:0] HALT = 32'hFFFF_FFFF;

  logic         clk;
  logic         reset;
  logic [R-1:0] readAddr;
  logic [N-1:0] instr;
  logic         redirect_valid;
  logic [R-1:0] redirect_addr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_instr;
  logic [R-1:0] out_pc;
  logic         halted;
  logic [1:0]   count;

  logic [N-1:0] mem [0:(1<<R)-1];

  int n_chk = 0;
  int n_err = 0;
  int n_deq = 0;
  int deq_snap;

  imem_fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .readAddr(readAddr),
    .instr(instr),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .count(count)
  );

  assign instr = mem[readAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && out_valid && out_ready) n_deq <= n_deq + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] word(input int a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk_reset(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_addr"}, readAddr, 0);
    check({tag, "_pc"}, out_pc, 0);
    check({tag, "_instr"}, out_instr, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << R); i++) mem[i] = word(i);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_reset("rst");

    // 1: streaming with decode always ready
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("s1_valid%0d", k), out_valid, 1);
      check($sformatf("s1_pc%0d", k), out_pc, k);
      check($sformatf("s1_instr%0d", k), out_instr, word(k));
      check($sformatf("s1_cnt%0d", k), count, 1);
    end

    // 2: backpressure fills the queue and freezes fetch
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("s2_cnt1", count, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("s2_cnt%0d", k), count, 2);
      check($sformatf("s2_addr%0d", k), readAddr, 2);
      check($sformatf("s2_instr%0d", k), out_instr, word(0));
    end
    out_ready = 1'b1;
    check("s2_take0", out_pc, 0);
    tick();
    check("s2_take1_pc", out_pc, 1);
    check("s2_take1_in", out_instr, word(1));
    check("s2_take1_cnt", count, 2);
    tick();
    check("s2_take2_pc", out_pc, 2);
    check("s2_take2_in", out_instr, word(2));

    // 3: redirect while full
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 7'h40;
    tick();
    redirect_valid = 1'b0;
    check("s3_cnt", count, 0);
    check("s3_valid", out_valid, 0);
    check("s3_addr", readAddr, 7'h40);
    out_ready = 1'b1;
    tick();
    check("s3_valid2", out_valid, 1);
    check("s3_pc", out_pc, 7'h40);
    check("s3_instr", out_instr, word(7'h40));

    // 4: halt word at 5
    mem[5] = HALT;
    redirect_valid = 1'b1;
    redirect_addr = 7'd4;
    tick();
    redirect_valid = 1'b0;
    check("s4_addr4", readAddr, 4);
    tick();
    check("s4_pc4", out_pc, 4);
    tick();
    check("s4_pc5", out_pc, 5);
    check("s4_hinstr", out_instr, HALT);
    check("s4_halted", halted, 1);
    tick();
    check("s4_empty", out_valid, 0);
    check("s4_addr6", readAddr, 6);
    tick();
    check("s4_empty2", out_valid, 0);
    check("s4_halted2", halted, 1);
    redirect_valid = 1'b1;
    redirect_addr = 7'd0;
    tick();
    redirect_valid = 1'b0;
    mem[5] = word(5);
    check("s4_resume_h", halted, 0);
    check("s4_resume_a", readAddr, 0);
    tick();
    check("s4_resume_v", out_valid, 1);
    check("s4_resume_pc", out_pc, 0);

    // 5: address wrap
    redirect_valid = 1'b1;
    redirect_addr = 7'h7F;
    tick();
    redirect_valid = 1'b0;
    check("s5_addr", readAddr, 7'h7F);
    tick();
    check("s5_pc7f", out_pc, 7'h7F);
    tick();
    check("s5_pc00", out_pc, 0);
    check("s5_in00", out_instr, word(0));

    // 6a: reset overrides a full queue and a redirect
    out_ready = 1'b0;
    tick();
    tick();
    check("s6_cnt", count, 2);
    check("s6_halted", halted, 0);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 7'h33;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    chk_reset("s6rst");

    // 6b: redirect and dequeue together
    out_ready = 1'b0;
    tick();
    tick();
    check("s6b_cnt", count, 2);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 7'h10;
    deq_snap = n_deq;
    tick();
    redirect_valid = 1'b0;
    check("s6b_one", n_deq - deq_snap, 1);
    check("s6b_empty", count, 0);
    check("s6b_addr", readAddr, 7'h10);
    tick();
    check("s6b_pc", out_pc, 7'h10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
